time_set_ctrl: RTL
==================

# time_set_ctrl

Edit-mode controller for the alarm clock's time-setting path. Sequences the digit pointer (3-bit one-hot point selector with `inc`, `resetn`, `max`, `active` inputs) through the four HH:MM digits and owns the BCD working copy of the time being edited. Emits a one-cycle commit strobe so the timekeeping or alarm register can load the edited value.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles in EDIT before automatic abort; legal range 2..2^20.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; all registers take reset values immediately.
- `mode_btn`  in  1  debounced, synchronous level; rising edge enters or commits edit.
- `next_btn`  in  1  debounced level; rising edge advances the digit pointer.
- `up_btn`  in  1  debounced level; rising edge increments the selected digit.
- `cur_time`  in  16  BCD HHMM (`[15:12]` hour tens … `[3:0]` minute ones); sampled on edit entry.
- `edit_time`  out  16  BCD working value.
- `digit_pos`  out  2  selected digit: 0 = hour tens, 1 = hour ones, 2 = minute tens, 3 = minute ones.
- `sel_inc`  out  1  to pointer `inc`.
- `sel_resetn`  out  1  to pointer `resetn` (active-low clear).
- `sel_active`  out  1  to pointer `active`.
- `sel_max`  out  3  constant 3'd4; the pointer wraps after count 3.
- `editing`  out  1  high in EDIT.
- `commit`  out  1  one-cycle strobe; `edit_time` is valid while high.

## Operation
- Edge detection: a registered copy of each button; press = btn & !btn_q. Reset value of each copy is 1, so a button held through reset does not register a press.
- Priority within one cycle: mode > next > up. Only the highest-priority press acts; the others are dropped, not queued.
- FSM states: IDLE, EDIT, COMMIT.
  - IDLE + mode press -> EDIT: `edit_time` <= `cur_time`, `digit_pos` <= 0, `sel_resetn` <= 0 for one cycle, timeout counter <= 0.
  - EDIT + mode press -> COMMIT.
  - EDIT + next press: `digit_pos` <= `digit_pos`+1 (3 wraps to 0); `sel_inc` <= 1 for one cycle.
  - EDIT + up press: increment digit `digit_pos` using these rules.
    - Hour tens: 0→1→2→0. On entering 2 with hour ones > 3, hour ones is forced to 3.
    - Hour ones: wraps 9→0 when hour tens < 2; wraps 3→0 when hour tens = 2.
    - Minute tens: 5→0.
    - Minute ones: 9→0.
  - EDIT with timeout counter = `TIMEOUT_CYCLES`-1 and no press -> IDLE with no commit. `edit_time` holds its value.
  - Any accepted press in EDIT clears the timeout counter. Otherwise the counter increments each cycle.
  - COMMIT -> IDLE unconditionally after one cycle. Presses during COMMIT are ignored.
- Outputs by state:
  - `editing` = `sel_active` = 1 in EDIT, 0 otherwise.
  - `commit` = 1 only in COMMIT.
  - `sel_max` = 3'd4 always.
- `cur_time` values that are not valid BCD are loaded as-is. Incrementing an out-of-range digit wraps it to 0.

## Timing
- All outputs are registered. A press sampled at edge n is reflected in the outputs after edge n.
- Entry: `editing`, `sel_active`, `edit_time` and `digit_pos` update on the same edge. `sel_resetn` is low for exactly that one cycle.
- `sel_inc` is high for one cycle, coinciding with the `digit_pos` update. The pointer count then equals `digit_pos` one cycle later.
- Commit: mode press at edge n gives `commit`=1 and `editing`=0 for the cycle after edge n. IDLE follows after edge n+1.
- Timeout: with no press, EDIT exits exactly `TIMEOUT_CYCLES` cycles after the last accepted press or entry.
- Reset values: `edit_time`=16'h0000, `digit_pos`=0, `sel_inc`=0, `sel_resetn`=0, `sel_active`=0, `editing`=0, `commit`=0, state IDLE, timeout counter 0.
- Reset asserted mid-edit aborts with no commit. The first cycle after release is IDLE with `sel_resetn`=1.

## Test plan
- Entry: `cur_time`=16'h1259, mode edge -> next cycle `editing`=1, `edit_time`=16'h1259, `digit_pos`=0, `sel_resetn`=0 for one cycle.
- Pointer wrap: four next edges in EDIT -> `digit_pos` goes 1,2,3,0; four single-cycle `sel_inc` pulses.
- Hour clamp: `edit_time`=16'h1959, `digit_pos`=0, one up edge -> 16'h2359. Then `digit_pos`=1 and one up edge -> 16'h2059.
- Minute wraps: from 16'h0859, up on pos 3 -> 16'h0850; up on pos 2 -> 16'h0800.
- Simultaneous press and commit: mode and up rising in the same cycle -> `commit`=1 and `edit_time` unchanged. Then IDLE, and a new up edge has no effect.
- Timeout and reset: `TIMEOUT_CYCLES`=8, no press -> `editing` drops after 8 cycles with `commit` never set. In a separate run, assert `reset` mid-edit -> all outputs take reset values immediately.

Source files
------------

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - edit-mode controller for HH:MM time setting with digit pointer control
module time_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        next_btn,
    input  logic        up_btn,
    input  logic [15:0] cur_time,
    output logic [15:0] edit_time,
    output logic [1:0]  digit_pos,
    output logic        sel_inc,
    output logic        sel_resetn,
    output logic        sel_active,
    output logic [2:0]  sel_max,
    output logic        editing,
    output logic        commit
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          mode_q;
    logic          next_q;
    logic          up_q;
    logic [CW-1:0] idle_cnt;

    // Copies reset high so a button held through reset is not seen as a press.
    logic mode_p;
    logic next_p;
    logic up_p;
    logic act_next;
    logic act_up;
    logic any_press;
    logic timed_out;

    assign mode_p    = mode_btn & ~mode_q;
    assign next_p    = next_btn & ~next_q;
    assign up_p      = up_btn & ~up_q;
    // Only the highest-priority press acts; lower ones in the same cycle are dropped.
    assign act_next  = next_p & ~mode_p;
    assign act_up    = up_p & ~mode_p & ~next_p;
    assign any_press = mode_p | next_p | up_p;
    assign timed_out = (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) && !any_press;

    assign sel_max = 3'd4;

    // Increment one BCD digit of HHMM, keeping the hour within 00..23.
    function automatic logic [15:0] bump_digit(input logic [15:0] t, input logic [1:0] pos);
        logic [3:0] ht;
        logic [3:0] ho;
        logic [3:0] mt;
        logic [3:0] mo;
        ht = t[15:12];
        ho = t[11:8];
        mt = t[7:4];
        mo = t[3:0];
        case (pos)
            2'd0: begin
                if (ht == 4'd0) begin
                    ht = 4'd1;
                end else if (ht == 4'd1) begin
                    ht = 4'd2;
                    if (ho > 4'd3) ho = 4'd3;
                end else begin
                    ht = 4'd0;
                end
            end
            2'd1: begin
                if (ht >= 4'd2) ho = (ho >= 4'd3) ? 4'd0 : ho + 4'd1;
                else            ho = (ho >= 4'd9) ? 4'd0 : ho + 4'd1;
            end
            2'd2: mt = (mt >= 4'd5) ? 4'd0 : mt + 4'd1;
            default: mo = (mo >= 4'd9) ? 4'd0 : mo + 4'd1;
        endcase
        return {ht, ho, mt, mo};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (mode_p) state_nxt = S_EDIT;
            S_EDIT: begin
                if (mode_p)         state_nxt = S_COMMIT;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        editing    = 1'b0;
        sel_active = 1'b0;
        commit     = 1'b0;
        case (state)
            S_EDIT: begin
                editing    = 1'b1;
                sel_active = 1'b1;
            end
            S_COMMIT: commit = 1'b1;
            default: ;
        endcase
    end

    // Button history registers for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 1'b1;
            next_q <= 1'b1;
            up_q   <= 1'b1;
        end else begin
            mode_q <= mode_btn;
            next_q <= next_btn;
            up_q   <= up_btn;
        end
    end

    // Working time copy, digit pointer, pointer strobes and idle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edit_time  <= 16'h0000;
            digit_pos  <= 2'd0;
            sel_inc    <= 1'b0;
            sel_resetn <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            sel_inc    <= 1'b0;
            sel_resetn <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (mode_p) begin
                        edit_time  <= cur_time;
                        digit_pos  <= 2'd0;
                        sel_resetn <= 1'b0;
                        idle_cnt   <= '0;
                    end
                end
                S_EDIT: begin
                    if (any_press) idle_cnt <= '0;
                    else           idle_cnt <= idle_cnt + CW'(1);
                    if (act_next) begin
                        digit_pos <= digit_pos + 2'd1;
                        sel_inc   <= 1'b1;
                    end
                    if (act_up) edit_time <= bump_digit(edit_time, digit_pos);
                end
                default: ;
            endcase
        end
    end

endmodule
